imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port 16-bit memory between the fetch stage (read-only instruction port) and the memory stage (read/write data port).
- Sequences each access as a multi-cycle transaction, completed by a memory done strobe.
- Returns read data with a one-cycle valid pulse and drives a stall back to each requester.
- Data port has priority; a starvation counter guarantees forward progress for fetch. Fetch flush support lets exceptions and redirects discard an in-flight instruction read.

Parameters:
- STARVE_MAX, 3: number of consecutive data grants allowed while fetch waits; the next arbitration goes to fetch. Legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; level, held until if_valid
- if_addr  in  16  fetch address; stable while if_req is high
- if_flush  in  1  discard any in-flight or pending fetch
- if_rdata  out  16  fetched instruction
- if_valid  out  1  one-cycle pulse; if_rdata is valid
- if_stall  out  1  fetch must hold
- d_req  in  1  data request; level, held until d_valid
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  16  data address
- d_wdata  in  16  write data
- d_rdata  out  16  read data
- d_valid  out  1  one-cycle completion pulse; also pulses for writes
- d_stall  out  1  memory stage must hold
- mem_en  out  1  memory access active
- mem_wr  out  1  memory write
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data; valid when mem_done is high
- mem_done  in  1  access complete this cycle

Behaviour:
- Reset (rst=0, async): state=IDLE, starve_cnt=0, flush_pend=0.
  - All outputs 0: if_rdata, d_rdata, if_valid, d_valid, mem_en, mem_wr, mem_addr, mem_wdata.
  - An access in progress at reset is abandoned; no valid pulse is produced.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, arbitration (on the clock edge):
  - If d_req and (starve_cnt<STARVE_MAX or !if_req): grant data, go to BUSY_D.
  - Else if if_req and !if_flush: grant fetch, go to BUSY_I.
  - Else stay in IDLE.
  - On grant, latch addr, wr and wdata into command registers.
- BUSY_x:
  - mem_en=1. mem_addr/mem_wr/mem_wdata are driven from the latched registers. mem_wr=0 always in BUSY_I.
  - Wait any number of cycles for mem_done.
  - On mem_done: capture mem_rdata into x_rdata (reads only; d_rdata is unchanged on writes). Pulse x_valid for one cycle, go to IDLE.
  - Minimum transaction is 2 cycles (grant edge, done edge), plus one IDLE turnaround cycle before the next grant.
- Starvation counter:
  - On a data grant while if_req=1: starve_cnt++, saturating at STARVE_MAX.
  - On a fetch grant: starve_cnt=0.
  - On a data grant with if_req=0: starve_cnt=0.
- Flush:
  - if_flush in IDLE blocks a fetch grant that cycle.
  - if_flush in BUSY_I sets flush_pend. The transaction still completes on the memory side. At mem_done, if flush_pend or if_flush is set: no if_valid, if_rdata is unchanged, flush_pend is cleared.
  - if_flush has no effect on BUSY_D.
- Stalls (combinational):
  - if_stall = if_req & !if_valid.
  - d_stall = d_req & !d_valid.
  - Requesters must drop or change req in the cycle after valid. The arbiter re-arbitrates only from IDLE, so a held req is serviced again only as a new transaction.
- mem_done in IDLE is ignored.
- Simultaneous d_req and if_req with starve_cnt==STARVE_MAX: fetch wins.
- Outputs other than the valid pulses and stalls are registered.

Test Plan:
- Reset release, if_req=1, if_addr=0x0010, mem_done 2 cycles after grant with mem_rdata=0xA5A5 -> mem_en high for exactly 2 cycles, mem_addr=0x0010, if_valid single pulse, if_rdata=0xA5A5, starve_cnt=0.
- if_req and d_req (write, addr 0x0200, wdata 0x1234) both high from IDLE -> data granted first (mem_wr=1, mem_wdata=0x1234), d_valid pulse, d_rdata unchanged; fetch granted after the one-cycle IDLE turnaround.
- if_req held high, d_req continuously re-asserted, STARVE_MAX=3 -> exactly 3 data grants, then a fetch grant, then starve_cnt=0.
- Fetch granted to 0x0040, if_flush pulsed one cycle mid-transaction, mem_done later -> no if_valid, if_rdata holds its prior value, next arbitration proceeds normally.
- rst driven low during BUSY_D (before mem_done) -> immediate return to IDLE, all outputs 0, no d_valid after reset release even if mem_done arrives.
- Data read at 0x0300 with mem_done asserted on the cycle right after grant, mem_rdata=0xBEEF -> d_valid on the following edge, d_rdata=0xBEEF, d_stall low in the same cycle as d_valid.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port 16-bit memory between an instruction fetch port
// (read-only) and a data port (read/write). The data port has priority.
// A starvation counter forces a fetch grant after STARVE_MAX back-to-back
// data grants while fetch waits. if_flush discards a pending or in-flight fetch.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req/if_addr/if_flush  fetch request, address, flush
//   if_rdata/if_valid        fetched instruction and its one-cycle valid pulse
//   if_stall                 fetch must hold (combinational)
//   d_req/d_wr/d_addr/d_wdata  data request, direction, address, write data
//   d_rdata/d_valid          read data and one-cycle completion pulse
//   d_stall                  memory stage must hold (combinational)
//   mem_en/mem_wr/mem_addr/mem_wdata  registered memory command
//   mem_rdata/mem_done       memory read data and completion strobe
module imem_dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_flush,
  output logic [15:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] starve_cnt, starve_cnt_nxt;
  logic          flush_pend, flush_pend_nxt;
  logic [DW-1:0] if_rdata_nxt, d_rdata_nxt;
  logic          if_valid_nxt, d_valid_nxt;
  logic          mem_en_nxt, mem_wr_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic          data_win;

  // Data wins unless fetch has waited through STARVE_MAX data grants
  assign data_win = d_req && ((starve_cnt < CW'(STARVE_MAX)) || !if_req);

  // Stalls are combinational so a requester sees its release in the valid cycle
  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  // State, command and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      flush_pend <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      flush_pend <= flush_pend_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      if_valid   <= if_valid_nxt;
      d_valid    <= d_valid_nxt;
      mem_en     <= mem_en_nxt;
      mem_wr     <= mem_wr_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
    end
  end

  // Arbitration, transaction sequencing and next register values
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    flush_pend_nxt = flush_pend;
    if_rdata_nxt   = if_rdata;
    d_rdata_nxt    = d_rdata;
    if_valid_nxt   = 1'b0;
    d_valid_nxt    = 1'b0;
    mem_en_nxt     = mem_en;
    mem_wr_nxt     = mem_wr;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;

    case (state)
      IDLE: begin
        if (data_win) begin
          state_nxt     = BUSY_D;
          mem_en_nxt    = 1'b1;
          mem_wr_nxt    = d_wr;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          if (if_req) begin
            if (starve_cnt != CW'(STARVE_MAX))
              starve_cnt_nxt = starve_cnt + CW'(1);
          end else begin
            starve_cnt_nxt = '0;
          end
        end else if (if_req && !if_flush) begin
          state_nxt      = BUSY_I;
          mem_en_nxt     = 1'b1;
          mem_wr_nxt     = 1'b0;
          mem_addr_nxt   = if_addr;
          mem_wdata_nxt  = '0;
          starve_cnt_nxt = '0;
          flush_pend_nxt = 1'b0;
        end
      end

      BUSY_I: begin
        if (if_flush)
          flush_pend_nxt = 1'b1;
        if (mem_done) begin
          state_nxt      = IDLE;
          mem_en_nxt     = 1'b0;
          flush_pend_nxt = 1'b0;
          // A flushed fetch still completes on the memory side but is dropped
          if (!(flush_pend || if_flush)) begin
            if_rdata_nxt = mem_rdata;
            if_valid_nxt = 1'b1;
          end
        end
      end

      BUSY_D: begin
        if (mem_done) begin
          state_nxt   = IDLE;
          mem_en_nxt  = 1'b0;
          mem_wr_nxt  = 1'b0;
          d_valid_nxt = 1'b1;
          if (!mem_wr)
            d_rdata_nxt = mem_rdata;
        end
      end

      default: begin
        state_nxt  = IDLE;
        mem_en_nxt = 1'b0;
        mem_wr_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed testbench for imem_dmem_arbiter: drives both requesters and
// plays the memory by hand, checking every output against fixed values.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, d_req, d_wr, mem_done;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, if_stall, d_valid, d_stall, mem_en, mem_wr;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    if_req = 0; if_flush = 0; d_req = 0; d_wr = 0; mem_done = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    #2;
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_if_valid", 32'(if_valid), 0);
    check("rst_d_valid", 32'(d_valid), 0);
    step();
    step();
    rst = 1'b1;

    // Single fetch, done two cycles after grant
    if_req = 1; if_addr = 16'h0010;
    step();
    check("t1_mem_en_c1", 32'(mem_en), 1);
    check("t1_mem_addr", 32'(mem_addr), 32'h0010);
    check("t1_mem_wr", 32'(mem_wr), 0);
    check("t1_if_stall", 32'(if_stall), 1);
    step();
    check("t1_mem_en_c2", 32'(mem_en), 1);
    check("t1_if_valid_early", 32'(if_valid), 0);
    mem_done = 1; mem_rdata = 16'hA5A5;
    step();
    mem_done = 0;
    check("t1_if_valid", 32'(if_valid), 1);
    check("t1_if_rdata", 32'(if_rdata), 32'hA5A5);
    check("t1_if_stall_rel", 32'(if_stall), 0);
    check("t1_mem_en_off", 32'(mem_en), 0);
    check("t1_starve", 32'(dut.starve_cnt), 0);
    if_req = 0;
    step();
    check("t1_if_valid_pulse", 32'(if_valid), 0);

    // Simultaneous requests: data write first, then fetch
    if_req = 1; if_addr = 16'h0020;
    d_req = 1; d_wr = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
    step();
    check("t2_mem_wr", 32'(mem_wr), 1);
    check("t2_mem_addr", 32'(mem_addr), 32'h0200);
    check("t2_mem_wdata", 32'(mem_wdata), 32'h1234);
    check("t2_d_stall", 32'(d_stall), 1);
    check("t2_starve", 32'(dut.starve_cnt), 1);
    mem_done = 1; mem_rdata = 16'hFFFF;
    step();
    mem_done = 0;
    check("t2_d_valid", 32'(d_valid), 1);
    check("t2_d_rdata_hold", 32'(d_rdata), 0);
    check("t2_mem_en_turn", 32'(mem_en), 0);
    check("t2_if_stall", 32'(if_stall), 1);
    d_req = 0; d_wr = 0;
    step();
    check("t2_fetch_grant", 32'(mem_en), 1);
    check("t2_fetch_addr", 32'(mem_addr), 32'h0020);
    check("t2_fetch_wr", 32'(mem_wr), 0);
    check("t2_starve_clr", 32'(dut.starve_cnt), 0);
    mem_done = 1; mem_rdata = 16'h1111;
    step();
    mem_done = 0;
    check("t2_if_valid", 32'(if_valid), 1);
    check("t2_if_rdata", 32'(if_rdata), 32'h1111);
    if_req = 0;
    step();

    // Starvation: fetch waits through exactly three data grants
    if_req = 1; if_addr = 16'h0030;
    d_req = 1; d_wr = 0; d_addr = 16'h0100;
    for (int g = 0; g < 3; g++) begin
      step();
      check("t3_data_addr", 32'(mem_addr), 32'h0100);
      check("t3_starve", 32'(dut.starve_cnt), 32'(g + 1));
      mem_done = 1; mem_rdata = 16'(16'h0100 + g);
      step();
      mem_done = 0;
      check("t3_d_valid", 32'(d_valid), 1);
      check("t3_d_rdata", 32'(d_rdata), 32'(16'h0100 + g));
    end
    step();
    check("t3_fetch_addr", 32'(mem_addr), 32'h0030);
    check("t3_fetch_en", 32'(mem_en), 1);
    check("t3_starve_clr", 32'(dut.starve_cnt), 0);
    mem_done = 1; mem_rdata = 16'h3333;
    step();
    mem_done = 0;
    check("t3_if_valid", 32'(if_valid), 1);
    check("t3_if_rdata", 32'(if_rdata), 32'h3333);
    check("t3_d_valid_none", 32'(d_valid), 0);
    if_req = 0; d_req = 0;
    step();

    // Flush mid-fetch drops the result
    if_req = 1; if_addr = 16'h0040;
    step();
    check("t4_grant_addr", 32'(mem_addr), 32'h0040);
    if_flush = 1;
    step();
    if_flush = 0;
    check("t4_flush_pend", 32'(dut.flush_pend), 1);
    check("t4_mem_en_hold", 32'(mem_en), 1);
    step();
    mem_done = 1; mem_rdata = 16'hDEAD;
    step();
    mem_done = 0;
    check("t4_no_valid", 32'(if_valid), 0);
    check("t4_rdata_hold", 32'(if_rdata), 32'h3333);
    check("t4_mem_en_off", 32'(mem_en), 0);
    check("t4_pend_clr", 32'(dut.flush_pend), 0);
    check("t4_if_stall", 32'(if_stall), 1);
    step();
    check("t4_regrant", 32'(mem_en), 1);
    mem_done = 1; mem_rdata = 16'h4444;
    step();
    mem_done = 0;
    check("t4_if_valid", 32'(if_valid), 1);
    check("t4_if_rdata", 32'(if_rdata), 32'h4444);
    // Flush while idle blocks the fetch grant
    if_flush = 1;
    step();
    check("t4_idle_flush_block", 32'(mem_en), 0);
    if_flush = 0; if_req = 0;
    step();

    // Reset during a data transaction
    d_req = 1; d_wr = 1; d_addr = 16'h0500; d_wdata = 16'h5555;
    step();
    check("t5_grant", 32'(mem_en), 1);
    step();
    rst = 0;
    #1;
    check("t5_mem_en", 32'(mem_en), 0);
    check("t5_mem_wr", 32'(mem_wr), 0);
    check("t5_mem_addr", 32'(mem_addr), 0);
    check("t5_mem_wdata", 32'(mem_wdata), 0);
    check("t5_d_rdata", 32'(d_rdata), 0);
    check("t5_if_rdata", 32'(if_rdata), 0);
    d_req = 0; d_wr = 0; mem_done = 1; mem_rdata = 16'h7777;
    step();
    rst = 1;
    step();
    check("t5_no_d_valid", 32'(d_valid), 0);
    check("t5_idle_en", 32'(mem_en), 0);
    step();
    check("t5_no_d_valid2", 32'(d_valid), 0);
    mem_done = 0;
    step();

    // Fastest data read: done in the cycle right after grant
    d_req = 1; d_wr = 0; d_addr = 16'h0300;
    step();
    check("t6_addr", 32'(mem_addr), 32'h0300);
    check("t6_wr", 32'(mem_wr), 0);
    mem_done = 1; mem_rdata = 16'hBEEF;
    step();
    mem_done = 0;
    check("t6_d_valid", 32'(d_valid), 1);
    check("t6_d_rdata", 32'(d_rdata), 32'hBEEF);
    check("t6_d_stall", 32'(d_stall), 0);
    d_req = 0;
    step();
    check("t6_d_valid_pulse", 32'(d_valid), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
